effect_noise_gate: RTL and testbench



---
 rtl/effect_noise_gate.sv | 112 +++++++++++
 tb/tb_effect_noise_gate.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/effect_noise_gate.sv
// effect_noise_gate: hysteretic noise gate with attack/hold/release gain ramp; ports i_clk, i_rst_n, i_valid, i_enable, i_level[2:0], i_data[15:0] -> o_data[15:0], o_valid, o_gate_open
module effect_noise_gate #(
  parameter int ENV_SHIFT    = 7,
  parameter int ATTACK_STEP  = 2048,
  parameter int RELEASE_STEP = 128,
  parameter int HOLD_SAMPLES = 4800
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid,
  output logic               o_gate_open
);
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam logic [11:0] TH [8] = '{12'd200, 12'd400, 12'd600, 12'd900, 12'd1200, 12'd1600, 12'd2000, 12'd2500};
  typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [15:0] gain_q, gain_d, sat_up, sat_dn;
  logic [16:0] gain_up, gain_dn;
  logic signed [16:0] env_q, env_d, sx, abs_v, diff, open_th, close_th;
  logic [HW-1:0] hold_q, hold_d;
  logic signed [15:0] data_q, data_d, scaled;
  logic signed [32:0] prod;
  logic valid_q, open_q, open_d;
  always_comb begin
    sx = {i_data[15], i_data};
    abs_v = (sx == -17'sd32768) ? 17'sd32767 : sx[16] ? -sx : sx;
    diff = abs_v - env_q;
    open_th = {5'd0, TH[i_level]};
    close_th = open_th - (open_th >>> 2);
    gain_up = {1'b0, gain_q} + 17'(ATTACK_STEP);
    gain_dn = {1'b0, gain_q} - 17'(RELEASE_STEP);
    sat_up = gain_up[16] ? 16'hFFFF : gain_up[15:0];
    sat_dn = gain_dn[16] ? 16'h0000 : gain_dn[15:0];
    prod = $signed(i_data) * $signed({1'b0, gain_q});
    scaled = 16'(prod >>> 16);
    state_d = state_q;
    gain_d = gain_q;
    hold_d = hold_q;
    env_d = env_q;
    data_d = data_q;
    open_d = open_q;
    if (i_valid) begin
      env_d = env_q + (diff >>> ENV_SHIFT);
      data_d = (!i_enable || gain_q == 16'hFFFF) ? i_data : (gain_q == 16'h0000) ? 16'sd0 : scaled;
      if (!i_enable) begin
        state_d = OPEN;
        gain_d = 16'hFFFF;
        hold_d = '0;
      end else begin
        case (state_q)
          CLOSED: begin
            gain_d = 16'h0000;
            if (env_q >= open_th) state_d = ATTACK;
          end
          ATTACK: begin
            gain_d = sat_up;
            if (sat_up == 16'hFFFF) state_d = OPEN;
          end
          OPEN: begin
            gain_d = 16'hFFFF;
            if (env_q < close_th) begin
              state_d = HOLD;
              hold_d = HW'(HOLD_SAMPLES);
            end
          end
          HOLD: begin
            gain_d = 16'hFFFF;
            if (env_q >= open_th) state_d = OPEN;
            else if (hold_q == HW'(1)) state_d = RELEASE;
            else hold_d = hold_q - HW'(1);
          end
          RELEASE: begin
            if (env_q >= open_th) state_d = ATTACK;
            else begin
              gain_d = sat_dn;
              if (sat_dn == 16'h0000) state_d = CLOSED;
            end
          end
          default: state_d = CLOSED;
        endcase
      end
      open_d = state_d != CLOSED;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLOSED;
      gain_q <= '0;
      env_q <= '0;
      hold_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      open_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q <= gain_d;
      env_q <= env_d;
      hold_q <= hold_d;
      data_q <= data_d;
      valid_q <= i_valid;
      open_q <= open_d;
    end
  end
  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_gate_open = open_q;
endmodule

// File: tb/tb_effect_noise_gate.sv
// tb_effect_noise_gate: directed and random stimulus against a sample-level behavioural model of the noise gate
module tb_effect_noise_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid = 1'b0;
  logic en = 1'b0;
  logic [2:0] lvl = 3'd0;
  logic signed [15:0] din = 16'sd0;
  logic signed [15:0] o_data;
  logic o_valid, o_gate_open;
  int tests = 0;
  int fails = 0;
  localparam int TH [8] = '{200, 400, 600, 900, 1200, 1600, 2000, 2500};
  localparam int SHUT = 0, RISE = 1, FULL = 2, WAIT = 3, FALL = 4;
  int m_env, m_gain, m_hold, m_out, m_open, m_mode;
  always #5 clk = ~clk;
  effect_noise_gate dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_enable(en), .i_level(lvl),
    .i_data(din), .o_data(o_data), .o_valid(o_valid), .o_gate_open(o_gate_open)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_env = 0; m_gain = 0; m_hold = 0; m_out = 0; m_open = 0; m_mode = SHUT;
  endtask
  task automatic model_step(input bit e, input int l, input int x);
    int a, th, cth, out;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    th = TH[l];
    cth = th - th / 4;
    if (!e || m_gain == 65535) out = x;
    else if (m_gain == 0) out = 0;
    else out = int'((longint'(x) * longint'(m_gain)) >>> 16);
    if (!e) begin
      m_mode = FULL; m_gain = 65535; m_hold = 0;
    end else if (m_mode == SHUT) begin
      m_gain = 0;
      if (m_env >= th) m_mode = RISE;
    end else if (m_mode == RISE) begin
      m_gain = (m_gain + 2048 > 65535) ? 65535 : m_gain + 2048;
      if (m_gain == 65535) m_mode = FULL;
    end else if (m_mode == FULL) begin
      if (m_env < cth) begin m_mode = WAIT; m_hold = 4800; end
    end else if (m_mode == WAIT) begin
      if (m_env >= th) m_mode = FULL;
      else if (m_hold == 1) m_mode = FALL;
      else m_hold--;
    end else begin
      if (m_env >= th) m_mode = RISE;
      else begin
        m_gain = (m_gain < 128) ? 0 : m_gain - 128;
        if (m_gain == 0) m_mode = SHUT;
      end
    end
    m_env = m_env + ((a - m_env) >>> 7);
    m_out = out;
    m_open = (m_mode != SHUT) ? 1 : 0;
  endtask
  task automatic step(input bit v, input bit e, input int l, input int x);
    @(negedge clk);
    valid = v; en = e; lvl = 3'(l); din = 16'(x);
    @(posedge clk);
    #1;
    if (v) model_step(e, l, x);
    chk("o_valid", int'(o_valid), int'(v));
    chk("o_data", int'(o_data), m_out);
    chk("o_gate_open", int'(o_gate_open), m_open);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      valid = i[0]; din = 16'sd1000; en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_o_data", int'(o_data), 0);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_gate", int'(o_gate_open), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
  endtask
  task automatic run_open(input int x, input int mid_exp);
    int n = 0;
    while (!o_gate_open && n < 1000) begin step(1, 1, 0, x); n++; end
    chk("open_bound", int'(n < 1000), 1);
    for (int j = 0; j < 16; j++) step(1, 1, 0, x);
    step(1, 1, 0, x);
    chk("mid_ramp", int'(o_data), mid_exp);
    for (int j = 17; j < 31; j++) step(1, 1, 0, x);
    step(1, 1, 0, x);
    chk("last_attack", int'(o_data), int'((longint'(x) * 63488) >>> 16));
    step(1, 1, 0, x);
    chk("unity", int'(o_data), x);
  endtask
  task automatic run_to_mode(input string tag, input int mode, input int x, input int lim);
    int n = 0;
    while (m_mode != mode && n < lim) begin step(1, 1, 0, x); n++; end
    chk(tag, int'(m_mode == mode), 1);
  endtask
  task automatic count_to_close(input string tag, input int exp);
    int n = 0;
    while (o_gate_open && n < 6000) begin step(1, 1, 0, 0); n++; end
    chk(tag, n, exp);
  endtask
  initial begin
    int o1, o2, g;
    bit loud;
    int l;
    do_reset();
    step(1, 1, 0, 0);
    chk("first_sample_zero", int'(o_data), 0);
    run_open(1000, 500);
    run_to_mode("hold_entry", WAIT, 0, 2000);
    count_to_close("hold_release_len", 5312);
    chk("closed_gate", int'(o_gate_open), 0);
    do_reset();
    run_open(-1000, -500);
    run_to_mode("hold_entry_neg", WAIT, 0, 2000);
    count_to_close("hold_release_len_neg", 5312);
    run_open(1000, 500);
    run_to_mode("hold_entry_100", WAIT, 100, 2000);
    for (int i = 0; i < 4800 + 384; i++) step(1, 1, 0, 100);
    chk("in_release", int'(m_mode == FALL), 1);
    run_to_mode("reattack", RISE, 1000, 500);
    g = m_gain;
    chk("reattack_gate", int'(o_gate_open), 1);
    step(1, 1, 0, 1000);
    o1 = int'(o_data);
    chk("reattack_held", o1, int'((longint'(1000) * g) >>> 16));
    step(1, 1, 0, 1000);
    o2 = int'(o_data);
    chk("ramp_step", int'((o2 - o1 == 31) || (o2 - o1 == 32)), 1);
    run_to_mode("reopen", FULL, 1000, 100);
    step(1, 0, 0, 1234);
    chk("bypass_a", int'(o_data), 1234);
    chk("bypass_gate", int'(o_gate_open), 1);
    step(1, 0, 0, -32768);
    chk("bypass_b", int'(o_data), -32768);
    step(1, 0, 0, 0);
    chk("bypass_c", int'(o_data), 0);
    step(1, 1, 0, 0);
    chk("reenable_open", int'(o_gate_open), 1);
    run_to_mode("reenable_hold", WAIT, 0, 2000);
    chk("reenable_gate", int'(o_gate_open), 1);
    do_reset();
    while (!o_gate_open && tests < 200000) step(1, 1, 0, 1000);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1000);
    o1 = int'(o_data);
    for (int i = 0; i < 10; i++) step(0, 1, 0, int'($urandom_range(0, 60000)) - 30000);
    chk("freeze_attack", int'(o_data), o1);
    run_to_mode("freeze_open", FULL, 1000, 100);
    run_to_mode("freeze_hold_entry", WAIT, 0, 2000);
    for (int i = 0; i < 100; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 5000);
    count_to_close("freeze_hold_len", 5212);
    do_reset();
    while (!o_gate_open && tests < 200000) step(1, 1, 0, 1000);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_o_data", int'(o_data), 0);
    chk("async_gate", int'(o_gate_open), 0);
    chk("async_valid", int'(o_valid), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 1000);
    chk("after_async", int'(o_data), 0);
    loud = 1'b0;
    l = 0;
    for (int i = 0; i < 3000; i++) begin
      int x;
      if (i % 250 == 0) begin loud = ~loud; l = int'($urandom_range(0, 7)); end
      x = loud ? int'($urandom_range(0, 8000)) - 4000 : int'($urandom_range(0, 100)) - 50;
      if ($urandom_range(0, 99) == 0) x = -32768;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) != 0, l, x);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
